// File: rtl/int_timers.sv
// int_timers: three-channel prescaled periodic/one-shot timer producing one-clock
// interrupt request strobes, programmed through a 16-entry I/O register window.
module int_timers #(
  parameter int NCH = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     addr,
  input  logic [7:0]     din,
  input  logic           wr_stb,
  input  logic           rd_stb,
  output logic [7:0]     dout,
  output logic [NCH-1:0] int_stbs
);
  logic [7:0] rd_v [16];
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic        en_q, en_d, os_q, stb_q;
    logic [1:0]  psel_q;
    logic [15:0] rld_q, cnt_q, cnt_d;
    logic [11:0] presc_q, presc_d, dm1;
    logic [7:0]  hold_q;
    logic        ctrl_wr, lo_wr, hi_wr, go_wr, hold_rd, restart, run, tick, expire;
    assign ctrl_wr = wr_stb && addr == 4'(4 * c);
    assign lo_wr   = wr_stb && addr == 4'(4 * c + 1);
    assign hi_wr   = wr_stb && addr == 4'(4 * c + 2);
    assign hold_rd = rd_stb && addr == 4'(4 * c + 3);
    assign go_wr   = wr_stb && addr == 4'hF && din[c];
    assign dm1 = psel_q == 2'd0 ? 12'd0 : psel_q == 2'd1 ? 12'd15 : psel_q == 2'd2 ? 12'd255 : 12'd4095;
    assign restart = go_wr || (ctrl_wr && (din[4] || (din[0] && !en_q)));
    // Any restart or disabling write in an expiring edge swallows that tick entirely.
    assign run    = en_q && !(ctrl_wr && !din[0]) && !restart;
    assign tick   = run && presc_q == dm1;
    assign expire = tick && cnt_q == 16'd1;
    assign en_d    = ctrl_wr ? din[0] : go_wr ? 1'b1 : (expire && os_q) ? 1'b0 : en_q;
    assign cnt_d   = restart ? rld_q : !tick ? cnt_q : cnt_q != 16'd1 ? cnt_q - 16'd1 : os_q ? 16'd0 : rld_q;
    assign presc_d = restart ? 12'd0 : !run ? presc_q : tick ? 12'd0 : presc_q + 12'd1;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        en_q    <= 1'b0;
        os_q    <= 1'b0;
        psel_q  <= 2'd0;
        rld_q   <= 16'd0;
        cnt_q   <= 16'd0;
        presc_q <= 12'd0;
        hold_q  <= 8'd0;
        stb_q   <= 1'b0;
      end else begin
        en_q <= en_d;
        if (ctrl_wr) begin
          os_q   <= din[1];
          psel_q <= din[3:2];
        end
        if (lo_wr) rld_q[7:0] <= din;
        if (hi_wr) rld_q[15:8] <= din;
        if (hold_rd) hold_q <= cnt_q[15:8];
        cnt_q   <= cnt_d;
        presc_q <= presc_d;
        stb_q   <= expire;
      end
    assign int_stbs[c]   = stb_q;
    assign rd_v[4*c]     = {4'b0, psel_q, os_q, en_q};
    assign rd_v[4*c+1]   = rld_q[7:0];
    assign rd_v[4*c+2]   = rld_q[15:8];
    assign rd_v[4*c+3]   = cnt_q[7:0];
    assign rd_v[12+c]    = hold_q;
  end
  assign rd_v[15] = 8'h00;
  assign dout = rd_v[addr];
endmodule

// File: tb/tb_int_timers.sv
// tb_int_timers: directed plus randomized checks of int_timers against a
// timing-arithmetic model (expiry = restart edge + k*reload*div).
module tb_int_timers;
  logic       clk = 0, rst_n = 0, wr_stb = 0, rd_stb = 0;
  logic [3:0] addr = 0;
  logic [7:0] din = 0;
  logic [7:0] dout;
  logic [2:0] int_stbs;
  int checks = 0, failures = 0, cyc = 0;
  bit m_en [3], m_os [3];
  int m_ps [3], m_rld [3], m_t0 [3], m_R [3], m_frz [3], m_hold [3];

  int_timers dut (.clk(clk), .rst_n(rst_n), .addr(addr), .din(din), .wr_stb(wr_stb),
                  .rd_stb(rd_stb), .dout(dout), .int_stbs(int_stbs));

  always #5 clk = ~clk;

  function automatic int dv(int c);
    return 1 << (4 * m_ps[c]);
  endfunction

  // Count value after edge n: reload minus whole ticks elapsed since restart, modulo the period.
  function automatic int cntv(int c, int n);
    if (!m_en[c]) return m_frz[c];
    return (m_R[c] - (((n - m_t0[c]) / dv(c)) % m_R[c])) & 16'hFFFF;
  endfunction

  function automatic bit expv(int c, int n);
    return m_en[c] && n > m_t0[c] && ((n - m_t0[c]) % (m_R[c] * dv(c))) == 0;
  endfunction

  function automatic int exp_rd(int a);
    int c = a / 4;
    if (a >= 15) return 0;
    if (a >= 12) return m_hold[a-12];
    case (a % 4)
      0: return m_ps[c] * 4 + int'(m_os[c]) * 2 + int'(m_en[c]);
      1: return m_rld[c] & 255;
      2: return m_rld[c] >> 8;
      default: return cntv(c, cyc) & 255;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic reset_model();
    for (int c = 0; c < 3; c++) begin
      m_en[c] = 0; m_os[c] = 0; m_ps[c] = 0; m_rld[c] = 0;
      m_t0[c] = 0; m_R[c] = 65536; m_frz[c] = 0; m_hold[c] = 0;
    end
  endtask

  task automatic restart(int c);
    m_t0[c]  = cyc;
    m_R[c]   = m_rld[c] == 0 ? 65536 : m_rld[c];
    m_frz[c] = m_rld[c];
  endtask

  task automatic edge_chk();
    logic [2:0] e;
    @(posedge clk);
    cyc++;
    for (int c = 0; c < 3; c++) begin
      bit ctrl = wr_stb && addr == 4 * c;
      bit go   = wr_stb && addr == 15 && din[c];
      bit rs   = go || (ctrl && (din[4] || (din[0] && !m_en[c])));
      int pre  = cntv(c, cyc - 1);
      e[c] = expv(c, cyc) && !rs && !(ctrl && !din[0]);
      if (rd_stb && addr == 4 * c + 3) m_hold[c] = pre >> 8;
      if (e[c] && m_os[c]) begin m_en[c] = 0; m_frz[c] = 0; end
      if (ctrl) begin
        if (!din[0]) m_frz[c] = pre;
        m_os[c] = din[1]; m_ps[c] = din[3:2]; m_en[c] = din[0];
      end
      if (go) m_en[c] = 1;
      if (rs) restart(c);
      if (wr_stb && addr == 4 * c + 1) m_rld[c] = (m_rld[c] & 'hFF00) | int'(din);
      if (wr_stb && addr == 4 * c + 2) m_rld[c] = (m_rld[c] & 'hFF) | (int'(din) << 8);
    end
    #1;
    chk("int_stbs", int_stbs, e);
    wr_stb = 0;
    rd_stb = 0;
  endtask

  task automatic wr(int a, int d);
    addr = a; din = d; wr_stb = 1;
    edge_chk();
  endtask

  task automatic idle(int n);
    repeat (n) edge_chk();
  endtask

  task automatic rd(string tag, int a, bit s);
    addr = a; rd_stb = s;
    #1;
    chk(tag, dout, exp_rd(a));
    edge_chk();
  endtask

  task automatic rst_reads(string tag);
    for (int a = 0; a < 16; a++) begin
      addr = a;
      #1;
      chk(tag, dout, 0);
    end
  endtask

  initial begin
    int c, n;
    reset_model();
    #12;
    chk("rst_stbs", int_stbs, 0);
    rst_reads("rst_rd");
    @(negedge clk) rst_n = 1;
    // ch0 periodic, reload 3, /1
    wr(1, 3); wr(2, 0); wr(0, 1);
    idle(10);
    addr = 0; #1; chk("ch0_ctrl_rd", dout, 8'h01);
    wr(0, 0);
    // ch1 one-shot, reload 2, /16
    wr(5, 2); wr(6, 0); wr(4, 7);
    idle(40);
    addr = 4; #1; chk("ch1_ctrl_rd", dout, 8'h06);
    idle(40);
    // ch2 reload 0 behaves as 65536, with a coherent LO/HOLD snapshot mid-run
    wr(8, 1);
    idle(30000);
    rd("ch2_cnt_lo", 11, 1); rd("ch2_hold", 14, 0);
    idle(20);
    rd("ch2_cnt_lo2", 11, 1); rd("ch2_hold2", 14, 0);
    idle(35540);
    wr(8, 0);
    // GO starts ch0 and ch1 together
    wr(1, 5); wr(5, 5); wr(4, 0); wr(15, 3);
    idle(16);
    wr(0, 0); wr(4, 0);
    // RESTART on the expiring edge, then reset during a live pulse
    wr(1, 4); wr(0, 1); idle(3); wr(0, 'h11);
    idle(8);
    chk("pulse_before_rst", int_stbs, 3'b001);
    rst_n = 0;
    #1;
    chk("rst_mid_stbs", int_stbs, 0);
    reset_model();
    rst_reads("rst_mid_rd");
    idle(2);
    @(negedge clk) rst_n = 1;
    // randomized programming and reads
    for (int it = 0; it < 40; it++) begin
      c = $urandom_range(0, 2);
      case ($urandom_range(0, 2))
        0: begin
          wr(4 * c, 0);
          wr(4 * c + 1, $urandom_range(1, 20));
          wr(4 * c + 2, 0);
          wr(4 * c, ($urandom_range(0, 1) << 4) | ($urandom_range(0, 1) << 2) | ($urandom_range(0, 1) << 1) | 1);
        end
        1: wr(4 * c, 'h10 | $urandom_range(0, 15));
        default: wr(15, $urandom_range(0, 7));
      endcase
      n = $urandom_range(0, 60);
      repeat (n)
        if ($urandom_range(0, 3) == 0) rd("rnd_rd", $urandom_range(0, 15), 1'($urandom_range(0, 1)));
        else edge_chk();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
